// File: rtl/mem_arbiter.sv
// Memory port arbiter: video/host share the read port (video first); host writes
// and a block-fill engine share the write port under round-robin arbitration.
module mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vid_req_i,
   input  logic [ADDR_W-1:0] vid_addr_i,
   output logic [DATA_W-1:0] vid_data_o,
   output logic              vid_valid_o,
   input  logic              host_rd_req_i,
   input  logic [ADDR_W-1:0] host_rd_addr_i,
   output logic              host_rd_ack_o,
   output logic [DATA_W-1:0] host_rd_data_o,
   output logic              host_rd_valid_o,
   input  logic              host_wr_req_i,
   input  logic [ADDR_W-1:0] host_wr_addr_i,
   input  logic [DATA_W-1:0] host_wr_data_i,
   output logic              host_wr_ack_o,
   input  logic              fill_start_i,
   input  logic [ADDR_W-1:0] fill_base_i,
   input  logic [ADDR_W:0]   fill_len_i,
   input  logic [DATA_W-1:0] fill_data_i,
   output logic              fill_busy_o,
   output logic              fill_done_o,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_rd_addr_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   output logic              mem_wr_en_o,
   output logic [ADDR_W-1:0] mem_wr_addr_o,
   output logic [DATA_W-1:0] mem_wr_data_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fill_state_t;

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   fill_state_t       state_q, state_d;
   logic [ADDR_W-1:0] fill_addr_q;
   logic [ADDR_W:0]   fill_cnt_q;
   logic [DATA_W-1:0] fill_data_q;
   logic              rr_host_q;
   logic              fill_req, grant_host, grant_fill;
   logic [DATA_W-1:0] vid_hold_q, host_hold_q;

   // Read port: purely combinational steering, video always wins.
   assign mem_rd_en_o   = vid_req_i | host_rd_req_i;
   assign mem_rd_addr_o = vid_req_i ? vid_addr_i : host_rd_addr_i;
   assign host_rd_ack_o = host_rd_req_i & ~vid_req_i;

   // Data is passed through in the cycle the memory returns it, else the last value.
   assign vid_data_o     = vid_valid_o     ? mem_rd_data_i : vid_hold_q;
   assign host_rd_data_o = host_rd_valid_o ? mem_rd_data_i : host_hold_q;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid_valid_o     <= 1'b0;
         host_rd_valid_o <= 1'b0;
         vid_hold_q      <= '0;
         host_hold_q     <= '0;
      end else begin
         vid_valid_o     <= vid_req_i;
         host_rd_valid_o <= host_rd_ack_o;
         if (vid_valid_o)     vid_hold_q  <= mem_rd_data_i;
         if (host_rd_valid_o) host_hold_q <= mem_rd_data_i;
      end
   end

   // rr_host_q set means host wins the next tie.
   assign fill_req      = (state_q == S_RUN);
   assign grant_host    = host_wr_req_i & (~fill_req | rr_host_q);
   assign grant_fill    = fill_req & (~host_wr_req_i | ~rr_host_q);
   assign host_wr_ack_o = grant_host;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_host_q     <= 1'b1;
         mem_wr_en_o   <= 1'b0;
         mem_wr_addr_o <= '0;
         mem_wr_data_o <= '0;
      end else begin
         mem_wr_en_o <= grant_host | grant_fill;
         if (grant_host) begin
            rr_host_q     <= 1'b0;
            mem_wr_addr_o <= host_wr_addr_i;
            mem_wr_data_o <= host_wr_data_i;
         end else if (grant_fill) begin
            rr_host_q     <= 1'b1;
            mem_wr_addr_o <= fill_addr_q;
            mem_wr_data_o <= fill_data_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: default assigned first so no path through the case leaves state_d
   // unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (fill_start_i) state_d = (fill_len_i == '0) ? S_DONE : S_RUN;
         S_RUN:  if (grant_fill && fill_cnt_q == CNT_ONE) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Address wraps naturally at ADDR_W bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_addr_q <= '0;
         fill_cnt_q  <= '0;
         fill_data_q <= '0;
      end else if (state_q == S_IDLE && fill_start_i) begin
         fill_addr_q <= fill_base_i;
         fill_cnt_q  <= fill_len_i;
         fill_data_q <= fill_data_i;
      end else if (grant_fill) begin
         fill_addr_q <= fill_addr_q + 1'b1;
         fill_cnt_q  <= fill_cnt_q - 1'b1;
      end
   end

   assign fill_busy_o = (state_q != S_IDLE);
   assign fill_done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vid_req_i, host_rd_req_i, host_wr_req_i, fill_start_i;
   logic [AW-1:0] vid_addr_i, host_rd_addr_i, host_wr_addr_i, fill_base_i;
   logic [AW:0]   fill_len_i;
   logic [DW-1:0] host_wr_data_i, fill_data_i, mem_rd_data_i;
   logic [DW-1:0] vid_data_o, host_rd_data_o, mem_wr_data_o;
   logic          vid_valid_o, host_rd_ack_o, host_rd_valid_o, host_wr_ack_o;
   logic          fill_busy_o, fill_done_o, mem_rd_en_o, mem_wr_en_o;
   logic [AW-1:0] mem_rd_addr_o, mem_wr_addr_o;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_data_o(vid_data_o),
      .vid_valid_o(vid_valid_o),
      .host_rd_req_i(host_rd_req_i), .host_rd_addr_i(host_rd_addr_i),
      .host_rd_ack_o(host_rd_ack_o), .host_rd_data_o(host_rd_data_o),
      .host_rd_valid_o(host_rd_valid_o),
      .host_wr_req_i(host_wr_req_i), .host_wr_addr_i(host_wr_addr_i),
      .host_wr_data_i(host_wr_data_i), .host_wr_ack_o(host_wr_ack_o),
      .fill_start_i(fill_start_i), .fill_base_i(fill_base_i), .fill_len_i(fill_len_i),
      .fill_data_i(fill_data_i), .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
      .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o),
      .mem_rd_data_i(mem_rd_data_i),
      .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o),
      .mem_wr_data_o(mem_wr_data_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: pending fill words are a queue of target addresses.
   logic [AW-1:0] fill_q[$];
   logic [DW-1:0] m_fill_data;
   bit            m_done_pend, m_host_last;
   bit            m_vid_valid, m_hrv, m_wr_en;
   logic [DW-1:0] m_vid_hold, m_host_hold, m_wr_data;
   logic [AW-1:0] m_wr_addr;
   bit            last_wack, last_rack;
   int            cyc;

   logic [AW-1:0] obs_addr[$];
   logic [DW-1:0] obs_data[$];
   int            obs_cyc[$];
   int            done_cnt;

   task automatic model_reset();
      fill_q.delete();
      m_fill_data = '0; m_done_pend = 0; m_host_last = 0;
      m_vid_valid = 0; m_hrv = 0; m_wr_en = 0;
      m_vid_hold = '0; m_host_hold = '0; m_wr_data = '0; m_wr_addr = '0;
      last_wack = 0; last_rack = 0;
   endtask

   task automatic clear_obs();
      obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); done_cnt = 0;
   endtask

   task automatic idle_inputs();
      vid_req_i = 0; host_rd_req_i = 0; host_wr_req_i = 0; fill_start_i = 0;
      vid_addr_i = '0; host_rd_addr_i = '0; host_wr_addr_i = '0; host_wr_data_i = '0;
      fill_base_i = '0; fill_len_i = '0; fill_data_i = '0;
      mem_rd_data_i = DW'($urandom);
   endtask

   // Called at a falling edge with inputs already applied; ends at the next falling edge.
   task automatic cycle();
      bit            freq, hwin, fwin, idle;
      logic [DW-1:0] e_vd, e_hd;
      #1;
      freq = (fill_q.size() != 0);
      hwin = host_wr_req_i && (!freq || !m_host_last);
      fwin = freq && !hwin;
      e_vd = m_vid_valid ? mem_rd_data_i : m_vid_hold;
      e_hd = m_hrv ? mem_rd_data_i : m_host_hold;
      check("rd_en",    32'(mem_rd_en_o),     32'(vid_req_i | host_rd_req_i));
      check("rd_addr",  32'(mem_rd_addr_o),   32'(vid_req_i ? vid_addr_i : host_rd_addr_i));
      check("rd_ack",   32'(host_rd_ack_o),   32'(host_rd_req_i & ~vid_req_i));
      check("wr_ack",   32'(host_wr_ack_o),   32'(hwin));
      check("vid_valid",32'(vid_valid_o),     32'(m_vid_valid));
      check("rd_valid", 32'(host_rd_valid_o), 32'(m_hrv));
      check("vid_data", 32'(vid_data_o),      32'(e_vd));
      check("rd_data",  32'(host_rd_data_o),  32'(e_hd));
      check("wr_en",    32'(mem_wr_en_o),     32'(m_wr_en));
      if (m_wr_en) begin
         check("wr_addr", 32'(mem_wr_addr_o), 32'(m_wr_addr));
         check("wr_data", 32'(mem_wr_data_o), 32'(m_wr_data));
      end
      check("busy", 32'(fill_busy_o), 32'(freq || m_done_pend));
      check("done", 32'(fill_done_o), 32'(m_done_pend));
      if (mem_wr_en_o) begin
         obs_addr.push_back(mem_wr_addr_o);
         obs_data.push_back(mem_wr_data_o);
         obs_cyc.push_back(cyc);
      end
      if (fill_done_o) done_cnt++;

      idle = !freq && !m_done_pend;
      if (m_vid_valid) m_vid_hold = mem_rd_data_i;
      if (m_hrv) m_host_hold = mem_rd_data_i;
      m_vid_valid = vid_req_i;
      m_hrv = host_rd_req_i && !vid_req_i;
      last_rack = m_hrv;
      last_wack = hwin;
      m_wr_en = hwin || fwin;
      m_done_pend = 0;
      if (hwin) begin
         m_wr_addr = host_wr_addr_i; m_wr_data = host_wr_data_i; m_host_last = 1;
      end else if (fwin) begin
         m_wr_addr = fill_q.pop_front(); m_wr_data = m_fill_data; m_host_last = 0;
         if (fill_q.size() == 0) m_done_pend = 1;
      end
      if (idle && fill_start_i) begin
         if (fill_len_i == '0) m_done_pend = 1;
         else begin
            m_fill_data = fill_data_i;
            for (int i = 0; i < int'(fill_len_i); i++) fill_q.push_back(fill_base_i + AW'(i));
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      vid_req_i  = ($urandom_range(0, 2) == 0);
      vid_addr_i = AW'($urandom);
      if (!host_rd_req_i || last_rack) begin
         host_rd_req_i  = ($urandom_range(0, 1) == 1);
         host_rd_addr_i = AW'($urandom);
      end
      if (!host_wr_req_i || last_wack) begin
         host_wr_req_i  = ($urandom_range(0, 2) != 0);
         host_wr_addr_i = AW'($urandom);
         host_wr_data_i = DW'($urandom);
      end
      fill_start_i  = ($urandom_range(0, 15) == 0);
      fill_base_i   = AW'($urandom);
      fill_len_i    = ($urandom_range(0, 7) == 0) ? '0 : (AW+1)'($urandom_range(1, 12));
      fill_data_i   = DW'($urandom);
      mem_rd_data_i = DW'($urandom);
   endtask

   initial begin
      int  hits[1 << AW];
      int  k, fills, once;
      bit  alt_ok, prev_fill;
      logic [AW-1:0] base;

      cyc = 0;
      idle_inputs();
      mem_rd_data_i = 8'h5A;
      model_reset();
      clear_obs();
      #12;
      check("rst_vid_valid", 32'(vid_valid_o),     32'd0);
      check("rst_rd_valid",  32'(host_rd_valid_o), 32'd0);
      check("rst_vid_data",  32'(vid_data_o),      32'd0);
      check("rst_rd_data",   32'(host_rd_data_o),  32'd0);
      check("rst_wr_en",     32'(mem_wr_en_o),     32'd0);
      check("rst_wr_addr",   32'(mem_wr_addr_o),   32'd0);
      check("rst_wr_data",   32'(mem_wr_data_o),   32'd0);
      check("rst_busy",      32'(fill_busy_o),     32'd0);
      check("rst_done",      32'(fill_done_o),     32'd0);
      @(negedge clk);
      rst_n = 1;

      // Video starves host read for three cycles, then host is acked.
      vid_req_i = 1; vid_addr_i = 10'h0AA; host_rd_req_i = 1; host_rd_addr_i = 10'h055;
      repeat (3) begin
         #1 check("req020_ack_blocked", 32'(host_rd_ack_o), 32'd0);
         cycle();
      end
      vid_req_i = 0;
      #1 check("req020_ack", 32'(host_rd_ack_o), 32'd1);
      cycle();
      host_rd_req_i = 0;
      #1 check("req020_valid", 32'(host_rd_valid_o), 32'd1);
      cycle();

      // Wrapping fill with no host traffic.
      clear_obs(); idle_inputs();
      fill_start_i = 1; fill_base_i = 10'h3FE; fill_len_i = 11'd4; fill_data_i = 8'hA5;
      cycle();
      fill_start_i = 0;
      repeat (8) cycle();
      check("req021_count", 32'(obs_addr.size()), 32'd4);
      check("req021_a0", 32'(obs_addr[0]), 32'h3FE);
      check("req021_a1", 32'(obs_addr[1]), 32'h3FF);
      check("req021_a2", 32'(obs_addr[2]), 32'h000);
      check("req021_a3", 32'(obs_addr[3]), 32'h001);
      check("req021_data", 32'(obs_data[3]), 32'hA5);
      check("req021_consec", 32'(obs_cyc[3] - obs_cyc[0]), 32'd3);
      check("req021_done_cnt", 32'(done_cnt), 32'd1);
      check("req021_busy_after", 32'(fill_busy_o), 32'd0);

      // Fill contending with a continuously held host write.
      clear_obs(); idle_inputs();
      k = 0;
      host_wr_req_i = 1; host_wr_addr_i = 10'h100; host_wr_data_i = 8'h3C;
      fill_start_i = 1; fill_base_i = 10'h200; fill_len_i = 11'd4; fill_data_i = 8'hC3;
      for (int n = 0; n < 14; n++) begin
         cycle();
         fill_start_i = 0;
         if (last_wack) begin k++; host_wr_addr_i = 10'h100 + AW'(k); end
      end
      host_wr_req_i = 0;
      repeat (2) cycle();
      fills = 0; alt_ok = 1; prev_fill = 0;
      foreach (obs_addr[i]) begin
         if (obs_addr[i][9:8] == 2'b10) begin
            fills++;
            if (prev_fill) alt_ok = 0;
            prev_fill = 1;
         end else prev_fill = 0;
      end
      check("req022_fill_writes", 32'(fills), 32'd4);
      check("req022_alternate", 32'(alt_ok), 32'd1);
      check("req022_done_cnt", 32'(done_cnt), 32'd1);

      // Zero-length fill completes without writing.
      clear_obs(); idle_inputs();
      fill_start_i = 1; fill_base_i = 10'h123; fill_len_i = '0;
      cycle();
      fill_start_i = 0;
      #1 check("req023_done", 32'(fill_done_o), 32'd1);
      repeat (4) cycle();
      check("req023_no_writes", 32'(obs_addr.size()), 32'd0);
      check("req023_done_cnt", 32'(done_cnt), 32'd1);

      // Reset aborts a fill after two of six writes.
      clear_obs(); idle_inputs();
      fill_start_i = 1; fill_base_i = 10'h050; fill_len_i = 11'd6; fill_data_i = 8'h77;
      cycle();
      fill_start_i = 0;
      for (int n = 0; n < 10 && obs_addr.size() < 2; n++) cycle();
      check("req024_two_written", 32'(obs_addr.size()), 32'd2);
      #2 rst_n = 0;
      #1;
      check("req024_wr_en", 32'(mem_wr_en_o), 32'd0);
      check("req024_busy",  32'(fill_busy_o), 32'd0);
      check("req024_done",  32'(fill_done_o), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      clear_obs();
      repeat (8) cycle();
      check("req024_no_more_writes", 32'(obs_addr.size()), 32'd0);
      check("req024_no_done", 32'(done_cnt), 32'd0);
      fill_start_i = 1; fill_base_i = 10'h3FF; fill_len_i = 11'd3; fill_data_i = 8'h11;
      cycle();
      fill_start_i = 0;
      repeat (6) cycle();
      check("req024_refill_writes", 32'(obs_addr.size()), 32'd3);
      check("req024_refill_done", 32'(done_cnt), 32'd1);

      // Full-size fill touches every address exactly once.
      clear_obs(); idle_inputs();
      base = AW'($urandom);
      fill_start_i = 1; fill_base_i = base; fill_len_i = 11'd1024; fill_data_i = 8'h5E;
      cycle();
      fill_start_i = 0;
      for (int n = 0; n < 1100 && done_cnt == 0; n++) cycle();
      repeat (2) cycle();
      foreach (hits[i]) hits[i] = 0;
      foreach (obs_addr[i]) hits[obs_addr[i]]++;
      once = 0;
      foreach (hits[i]) if (hits[i] == 1) once++;
      check("req015_total", 32'(obs_addr.size()), 32'd1024);
      check("req015_each_once", 32'(once), 32'd1024);
      check("req015_done_cnt", 32'(done_cnt), 32'd1);

      // Randomized traffic against the model.
      idle_inputs();
      repeat (3000) begin
         rand_inputs();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
